regfile_sequencer: RTL and testbench

REGFILE_SEQUENCER -- requirements
Module: regfile_sequencer

---
 rtl/regfile_sequencer.sv | 176 +++++++++++++++++
 tb/tb_regfile_sequencer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sequencer.sv
`timescale 1ns/1ps
// regfile_sequencer
// Fetches one 32-bit instruction at a time over a valid/ready handshake,
// reads its operands from an external register file, computes the result
// and writes it back.
//
// Instruction format: opcode[31:24] dest[18:16] src1[10:8] src2[2:0] imm[7:0]
// Opcodes: 00 LOADI, 01 MOV (dest=src2), 02 ADD, 03 SUB, 04 AND, 05 OR.
// Every other opcode is illegal and retires through FAULT with an ERR pulse.
//
// Ports
//   CLK, RESET             clock, synchronous active-high reset
//   INSTR, INSTR_VALID     instruction word and its valid strobe
//   INSTR_READY            high only while idle
//   RF_OUT1ADDR/2ADDR      register-file read addresses (held outside READ/EXEC)
//   RF_OUT1/RF_OUT2        register-file read data (combinational)
//   RF_INADDR, RF_IN       register-file write address / data
//   RF_WRITE               register-file write enable, one cycle per legal instr
//   DONE                   one-cycle pulse alongside RF_WRITE
//   ERR                    one-cycle pulse for an illegal opcode
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | ready; accepts an instruction when INSTR_VALID is high
// READ  | read addresses presented to the register file
// EXEC  | read data settles; result registered at the closing edge
// WRITE | RF_WRITE/DONE high, result written at the exit edge
// FAULT | illegal opcode, ERR high for one cycle

module regfile_sequencer #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [31:0]       INSTR,
    input  logic              INSTR_VALID,
    output logic              INSTR_READY,
    output logic [ADDR_W-1:0] RF_OUT1ADDR,
    output logic [ADDR_W-1:0] RF_OUT2ADDR,
    input  logic [DATA_W-1:0] RF_OUT1,
    input  logic [DATA_W-1:0] RF_OUT2,
    output logic [ADDR_W-1:0] RF_INADDR,
    output logic [DATA_W-1:0] RF_IN,
    output logic              RF_WRITE,
    output logic              DONE,
    output logic              ERR
);

    localparam logic [7:0] OP_LOADI = 8'h00;
    localparam logic [7:0] OP_MOV   = 8'h01;
    localparam logic [7:0] OP_ADD   = 8'h02;
    localparam logic [7:0] OP_SUB   = 8'h03;
    localparam logic [7:0] OP_AND   = 8'h04;
    localparam logic [7:0] OP_OR    = 8'h05;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_EXEC,
        S_WRITE,
        S_FAULT
    } state_t;

    state_t            state_q;
    logic [7:0]        op_q;
    logic [ADDR_W-1:0] dest_q;
    logic [ADDR_W-1:0] out1addr_q;
    logic [ADDR_W-1:0] out2addr_q;
    logic [ADDR_W-1:0] inaddr_q;
    logic [DATA_W-1:0] in_q;
    logic              write_q;
    logic              done_q;
    logic              err_q;
    logic [DATA_W-1:0] result_d;

    logic [7:0]        op_in;
    logic [ADDR_W-1:0] dest_in;
    logic [ADDR_W-1:0] src1_in;
    logic [ADDR_W-1:0] src2_in;
    logic [DATA_W-1:0] imm_in;
    logic              unused_instr;

    assign op_in        = INSTR[31:24];
    assign dest_in      = INSTR[16 +: ADDR_W];
    assign src1_in      = INSTR[8 +: ADDR_W];
    assign src2_in      = INSTR[0 +: ADDR_W];
    assign imm_in       = INSTR[DATA_W-1:0];
    assign unused_instr = ^{INSTR[23:19], INSTR[15:11]};

    // Evaluated from the live read data during EXEC; the register at the
    // closing EXEC edge is in_q. Results wrap at DATA_W bits.
    always_comb begin
        result_d = '0;
        case (op_q)
            OP_MOV:  result_d = RF_OUT2;
            OP_ADD:  result_d = RF_OUT1 + RF_OUT2;
            OP_SUB:  result_d = RF_OUT1 - RF_OUT2;
            OP_AND:  result_d = RF_OUT1 & RF_OUT2;
            OP_OR:   result_d = RF_OUT1 | RF_OUT2;
            default: result_d = '0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= S_IDLE;
            op_q       <= '0;
            dest_q     <= '0;
            out1addr_q <= '0;
            out2addr_q <= '0;
            inaddr_q   <= '0;
            in_q       <= '0;
            write_q    <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            write_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (INSTR_VALID) begin
                        op_q   <= op_in;
                        dest_q <= dest_in;
                        case (op_in)
                            OP_LOADI: begin
                                // No operands to read: straight to WRITE.
                                state_q  <= S_WRITE;
                                write_q  <= 1'b1;
                                done_q   <= 1'b1;
                                inaddr_q <= dest_in;
                                in_q     <= imm_in;
                            end
                            OP_MOV, OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                                state_q    <= S_READ;
                                out1addr_q <= src1_in;
                                out2addr_q <= src2_in;
                            end
                            default: begin
                                state_q <= S_FAULT;
                                err_q   <= 1'b1;
                            end
                        endcase
                    end
                end
                S_READ: begin
                    state_q <= S_EXEC;
                end
                S_EXEC: begin
                    state_q  <= S_WRITE;
                    write_q  <= 1'b1;
                    done_q   <= 1'b1;
                    inaddr_q <= dest_q;
                    in_q     <= result_d;
                end
                S_WRITE, S_FAULT: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign INSTR_READY = (state_q == S_IDLE);
    assign RF_OUT1ADDR = out1addr_q;
    assign RF_OUT2ADDR = out2addr_q;
    assign RF_INADDR   = inaddr_q;
    assign RF_IN       = in_q;
    assign RF_WRITE    = write_q;
    assign DONE        = done_q;
    assign ERR         = err_q;

endmodule

// File: tb/tb_regfile_sequencer.sv
`timescale 1ns/1ps
// Testbench for regfile_sequencer: directed vector table, hand-written
// multi-cycle sequences and a randomized run, all checked against a
// transaction-level model of the sequencer plus a register file.

module tb_regfile_sequencer;

    localparam int DW = 8;
    localparam int AW = 3;

    logic          CLK = 1'b0;
    logic          RESET;
    logic [31:0]   INSTR;
    logic          INSTR_VALID;
    logic          INSTR_READY;
    logic [AW-1:0] RF_OUT1ADDR, RF_OUT2ADDR, RF_INADDR;
    logic [DW-1:0] RF_OUT1, RF_OUT2, RF_IN;
    logic          RF_WRITE, DONE, ERR;

    regfile_sequencer #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .INSTR       (INSTR),
        .INSTR_VALID (INSTR_VALID),
        .INSTR_READY (INSTR_READY),
        .RF_OUT1ADDR (RF_OUT1ADDR),
        .RF_OUT2ADDR (RF_OUT2ADDR),
        .RF_OUT1     (RF_OUT1),
        .RF_OUT2     (RF_OUT2),
        .RF_INADDR   (RF_INADDR),
        .RF_IN       (RF_IN),
        .RF_WRITE    (RF_WRITE),
        .DONE        (DONE),
        .ERR         (ERR)
    );

    always #5 CLK = ~CLK;

    // Register file attached to the DUT.
    logic [DW-1:0] rf [8] = '{default: '0};
    assign RF_OUT1 = rf[RF_OUT1ADDR];
    assign RF_OUT2 = rf[RF_OUT2ADDR];
    always @(posedge CLK) if (RF_WRITE) rf[RF_INADDR] <= RF_IN;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    // An accepted instruction keeps the sequencer busy for m_left edges
    // (3 for register ops, 1 for LOADI/illegal); its write or error is
    // visible during the last busy cycle and lands on the exit edge.
    logic [DW-1:0] m_rf [8] = '{default: '0};
    int            m_left = 0;
    bit            m_wpend = 0, m_epend = 0;
    logic [AW-1:0] m_dest = '0;
    logic [DW-1:0] m_val = '0;
    bit            m_wr = 0, m_err = 0, m_zero = 1;
    logic [AW-1:0] m_ra1 = '0, m_ra2 = '0, m_wa = '0;
    logic [DW-1:0] m_wd = '0;
    int            acc_cnt = 0;

    always @(posedge CLK) begin
        bit            rdy;
        logic [7:0]    op;
        logic [AW-1:0] d, s1, s2;
        logic [DW-1:0] imm;
        rdy = (m_left == 0);
        if (m_left == 1 && m_wpend) m_rf[m_dest] = m_val;
        if (m_left > 0) m_left--;
        m_wr  = 0;
        m_err = 0;
        if (RESET) begin
            m_left = 0; m_wpend = 0; m_epend = 0;
            m_ra1 = '0; m_ra2 = '0; m_wa = '0; m_wd = '0; m_zero = 1;
        end else if (rdy && INSTR_VALID) begin
            op  = INSTR[31:24];
            d   = INSTR[18:16];
            s1  = INSTR[10:8];
            s2  = INSTR[2:0];
            imm = INSTR[7:0];
            acc_cnt++;
            m_dest  = d;
            m_wpend = 1;
            m_epend = 0;
            m_left  = 3;
            case (op)
                8'h00: begin m_val = imm; m_left = 1; end
                8'h01: m_val = m_rf[s2];
                8'h02: m_val = m_rf[s1] + m_rf[s2];
                8'h03: m_val = m_rf[s1] - m_rf[s2];
                8'h04: m_val = m_rf[s1] & m_rf[s2];
                8'h05: m_val = m_rf[s1] | m_rf[s2];
                default: begin m_left = 1; m_wpend = 0; m_epend = 1; end
            endcase
            if (op >= 8'h01 && op <= 8'h05) begin
                m_ra1 = s1;
                m_ra2 = s2;
            end
        end
        if (m_left == 1 && m_wpend) begin
            m_wr = 1; m_wa = m_dest; m_wd = m_val; m_zero = 0;
        end
        if (m_left == 1 && m_epend) m_err = 1;
    end

    // Cycle-by-cycle comparison of every output against the model.
    always @(negedge CLK) begin
        if (chk_en) begin
            chk("ready",    32'(INSTR_READY), 32'(m_left == 0));
            chk("rf_write", 32'(RF_WRITE),    32'(m_wr));
            chk("done",     32'(DONE),        32'(m_wr));
            chk("err",      32'(ERR),         32'(m_err));
            chk("raddr1",   32'(RF_OUT1ADDR), 32'(m_ra1));
            chk("raddr2",   32'(RF_OUT2ADDR), 32'(m_ra2));
            if (m_wr || m_zero) begin
                chk("waddr", 32'(RF_INADDR), 32'(m_wa));
                chk("wdata", 32'(RF_IN),     32'(m_wd));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // Present ins and hold it until the model says it was accepted.
    // Returns at the negedge of the first cycle after the accept edge.
    task automatic issue(input logic [31:0] ins);
        int guard = 0;
        INSTR       = ins;
        INSTR_VALID = 1'b1;
        while (m_left != 0 && guard < 20) begin
            @(negedge CLK);
            guard++;
        end
        if (guard >= 20) chk("issue_timeout", 32'(guard), 32'd0);
        @(negedge CLK);
        INSTR_VALID = 1'b0;
    endtask

    typedef struct {
        logic [31:0]   ins;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            lat;
    } vec_t;

    vec_t vecs [11];
    logic [31:0] prog [3];

    initial begin
        int n;
        int dut_acc;
        int base;
        int k;
        logic [7:0] op;

        vecs[0]  = '{32'h0002005F, 3'd2, 8'h5F, 1};  // LOADI r2,95
        vecs[1]  = '{32'h0001001C, 3'd1, 8'h1C, 1};  // LOADI r1,28
        vecs[2]  = '{32'h02030102, 3'd3, 8'h7B, 3};  // ADD r3,r1,r2 = 123
        vecs[3]  = '{32'h00040000, 3'd4, 8'h00, 1};  // LOADI r4,0
        vecs[4]  = '{32'h00050001, 3'd5, 8'h01, 1};  // LOADI r5,1
        vecs[5]  = '{32'h03060405, 3'd6, 8'hFF, 3};  // SUB r6,r4,r5 = 0xFF
        vecs[6]  = '{32'h000400FF, 3'd4, 8'hFF, 1};  // LOADI r4,0xFF
        vecs[7]  = '{32'h02070405, 3'd7, 8'h00, 3};  // ADD r7,r4,r5 wraps to 0
        vecs[8]  = '{32'h04000306, 3'd0, 8'h7B, 3};  // AND r0,r3,r6
        vecs[9]  = '{32'h05010205, 3'd1, 8'h5F, 3};  // OR r1,r2,r5
        vecs[10] = '{32'h01020006, 3'd2, 8'hFF, 3};  // MOV r2,r6

        prog[0] = 32'h0003003C;  // LOADI r3,0x3C
        prog[1] = 32'h01010003;  // MOV r1,r3
        prog[2] = 32'h02000103;  // ADD r0,r1,r3 = 0x78

        RESET = 1'b1; INSTR_VALID = 1'b0; INSTR = '0;
        repeat (2) @(negedge CLK);
        chk_en = 1'b1;
        chk("rst_ready",  32'(INSTR_READY), 32'd1);
        chk("rst_write",  32'(RF_WRITE),    32'd0);
        chk("rst_inaddr", 32'(RF_INADDR),   32'd0);
        chk("rst_in",     32'(RF_IN),       32'd0);
        RESET = 1'b0;
        @(negedge CLK);

        // Directed table.
        foreach (vecs[i]) begin
            issue(vecs[i].ins);
            n = 1;
            while (!RF_WRITE && n < 8) begin
                @(negedge CLK);
                n++;
            end
            chk($sformatf("vec%0d_lat", i),  32'(n),         32'(vecs[i].lat));
            chk($sformatf("vec%0d_addr", i), 32'(RF_INADDR), 32'(vecs[i].addr));
            chk($sformatf("vec%0d_data", i), 32'(RF_IN),     32'(vecs[i].data));
            chk($sformatf("vec%0d_done", i), 32'(DONE),      32'd1);
            @(negedge CLK);
        end

        // Illegal opcode 0x09.
        issue(32'h09010203);
        chk("ill_err",    32'(ERR),         32'd1);
        chk("ill_write",  32'(RF_WRITE),    32'd0);
        chk("ill_ready0", 32'(INSTR_READY), 32'd0);
        @(negedge CLK);
        chk("ill_err_off", 32'(ERR),         32'd0);
        chk("ill_ready1",  32'(INSTR_READY), 32'd1);

        // INSTR_VALID held high across three instructions.
        base = acc_cnt; dut_acc = 0; INSTR_VALID = 1'b1; INSTR = prog[0];
        for (int c = 0; c < 30; c++) begin
            k = acc_cnt - base;
            if (k >= 3) INSTR_VALID = 1'b0;
            else        INSTR = prog[k];
            if (INSTR_VALID && INSTR_READY) dut_acc++;
            @(negedge CLK);
        end
        INSTR_VALID = 1'b0;
        chk("held_accepts", 32'(dut_acc), 32'd3);
        chk("held_r1",      32'(rf[1]),   32'h3C);
        chk("held_r0",      32'(rf[0]),   32'h78);

        // Reset during EXEC of ADD r5,r1,r2.
        issue(32'h02050102);
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        chk("rexec_write",  32'(RF_WRITE),    32'd0);
        chk("rexec_done",   32'(DONE),        32'd0);
        chk("rexec_ready",  32'(INSTR_READY), 32'd1);
        chk("rexec_ra1",    32'(RF_OUT1ADDR), 32'd0);
        chk("rexec_ra2",    32'(RF_OUT2ADDR), 32'd0);
        chk("rexec_inaddr", 32'(RF_INADDR),   32'd0);
        repeat (4) @(negedge CLK);
        chk("rexec_r5", 32'(rf[5]), 32'(m_rf[5]));

        // Reset wins over a handshake at the same edge.
        RESET = 1'b1; INSTR = 32'h00060011; INSTR_VALID = 1'b1;
        @(negedge CLK);
        RESET = 1'b0; INSTR_VALID = 1'b0;
        chk("rprio_ready", 32'(INSTR_READY), 32'd1);
        @(negedge CLK);
        chk("rprio_write", 32'(RF_WRITE), 32'd0);

        // Randomized run against the model.
        for (int c = 0; c < 600; c++) begin
            RESET       = ($urandom_range(0, 99) == 0);
            INSTR_VALID = ($urandom_range(0, 2) != 0);
            op = 8'($urandom_range(0, 7));
            if (op > 8'h05) op = 8'($urandom_range(6, 255));
            INSTR = {op, 24'($urandom)};
            @(negedge CLK);
        end
        RESET = 1'b0; INSTR_VALID = 1'b0;
        repeat (5) @(negedge CLK);
        for (int r = 0; r < 8; r++) chk($sformatf("final_r%0d", r), 32'(rf[r]), 32'(m_rf[r]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
